// File: rtl/qk_score_if.sv
// qk_score_if
//   Groups the K-load, Q-load and score-stream signals of qk_score_unit.
//   The slave modport is the scoring unit. The master modport is the DMA
//   side that loads K and Q and consumes scores.
//   K beat   : en_loadk, k_valid, k_input, k_address -> input_done_ld_k, k_full
//   Q row    : q_valid, q_input -> q_accept
//   Score    : score_qk_output, score_idx, score_valid <- score_ready; done_qk
//   Rows are D_K elements of DATA_WIDTH bits, with element 0 in the MSBs.
interface qk_score_if #(
   parameter int DATA_WIDTH     = 8,
   parameter int D_K            = 4,
   parameter int SEQ_LENGTH_BIT = 2,
   parameter int SCORE_WIDTH    = 32
) ();
   logic                          en_loadk;
   logic                          k_valid;
   logic [D_K*DATA_WIDTH-1:0]     k_input;
   logic [SEQ_LENGTH_BIT-1:0]     k_address;
   logic                          input_done_ld_k;
   logic                          k_full;
   logic                          q_valid;
   logic [D_K*DATA_WIDTH-1:0]     q_input;
   logic                          q_accept;
   logic [SCORE_WIDTH-1:0]        score_qk_output;
   logic [SEQ_LENGTH_BIT-1:0]     score_idx;
   logic                          score_valid;
   logic                          score_ready;
   logic                          done_qk;

   modport slave (
      input  en_loadk, k_valid, k_input, k_address, q_valid, q_input, score_ready,
      output input_done_ld_k, k_full, q_accept, score_qk_output, score_idx,
             score_valid, done_qk
   );

   modport master (
      output en_loadk, k_valid, k_input, k_address, q_valid, q_input, score_ready,
      input  input_done_ld_k, k_full, q_accept, score_qk_output, score_idx,
             score_valid, done_qk
   );
endinterface

// File: rtl/qk_score_unit.sv
// qk_score_unit
//   Stores SEQ_LENGTH key rows and scores one query row against every stored
//   row. Each score is a signed dot product that is computed one element per
//   cycle. Scores leave through a valid/ready handshake, one per row, with
//   row 0 first. done_qk pulses after the last score has been accepted.
//
// Ports
//   clk  : rising-edge clock
//   rst  : asynchronous active-low reset
//   bus  : qk_score_if.slave (K load, Q load and score stream)
//
// Build option
//   QK_SCORE_SCALE_EN : when defined, each final sum is arithmetically
//                       right-shifted by SCALE_SHIFT before sign extension.
//                       Latency is the same in both builds.
module qk_score_unit #(
   parameter int DATA_WIDTH     = 8,
   parameter int D_K            = 4,
   parameter int SEQ_LENGTH_BIT = 2,
   parameter int SCORE_WIDTH    = 32,
   parameter int SCALE_SHIFT    = 1
) (
   input  logic       clk,
   input  logic       rst,
   qk_score_if.slave  bus
);
   localparam int SEQ_LENGTH = 1 << SEQ_LENGTH_BIT;
   localparam int ROW_W      = D_K * DATA_WIDTH;
   localparam int PROD_W     = 2 * DATA_WIDTH;
   localparam int ACC_W      = 2 * DATA_WIDTH + $clog2(D_K) + 1;
   localparam int ELEM_W     = $clog2(D_K + 1);
   localparam int ELEM_IDX_W = (D_K > 1) ? $clog2(D_K) : 1;
`ifdef QK_SCORE_SCALE_EN
   localparam bit SCALE_EN   = 1'b1;
`else
   localparam bit SCALE_EN   = 1'b0;
`endif
   localparam int SHIFT_AMT  = SCALE_EN ? SCALE_SHIFT : 0;

   localparam logic [ELEM_W-1:0]         LAST_ELEM = ELEM_W'(D_K - 1);
   localparam logic [ELEM_W-1:0]         ELEM_END  = ELEM_W'(D_K);
   localparam logic [SEQ_LENGTH_BIT-1:0] LAST_ROW  = SEQ_LENGTH_BIT'(SEQ_LENGTH - 1);

   typedef enum logic [1:0] {IDLE, LOADK, COMPUTE, OUT} state_t;

   state_t                        state, state_nxt;
   logic [ROW_W-1:0]              k_bank [SEQ_LENGTH];
   logic [SEQ_LENGTH-1:0]         row_valid;
   logic [ROW_W-1:0]              q_row;
   logic [SEQ_LENGTH_BIT-1:0]     row;
   logic [ELEM_W-1:0]             elem;
   logic signed [PROD_W-1:0]      prod_p0;
   logic                          vld_p0;
   logic                          last_p0;
   logic signed [ACC_W-1:0]       acc;

   logic                          done_ld_k;
   logic                          q_accept;
   logic [SCORE_WIDTH-1:0]        score;
   logic [SEQ_LENGTH_BIT-1:0]     score_idx;
   logic                          score_valid;
   logic                          done_qk;

   logic                          k_full;
   logic [ELEM_IDX_W-1:0]         elem_idx;
   logic signed [DATA_WIDTH-1:0]  q_elem, k_elem;
   logic signed [PROD_W-1:0]      prod_c;
   logic signed [ACC_W-1:0]       prod_ext, acc_sum;

   // Element i of a row sits at the MSB end when i = 0.
   function automatic logic signed [DATA_WIDTH-1:0] pick_elem(
      input logic [ROW_W-1:0]      r,
      input logic [ELEM_IDX_W-1:0] i);
      return r[(D_K - 1 - int'(i)) * DATA_WIDTH +: DATA_WIDTH];
   endfunction

   // Optional floor scaling (arithmetic shift), then sign-extend to the output width.
   function automatic logic [SCORE_WIDTH-1:0] finalize_score(
      input logic signed [ACC_W-1:0] sum);
      logic signed [ACC_W-1:0] s;
      s = sum >>> SHIFT_AMT;
      return {{(SCORE_WIDTH - ACC_W){s[ACC_W-1]}}, s};
   endfunction

   assign k_full = &row_valid;

   always_comb begin
      elem_idx = elem[ELEM_IDX_W-1:0];
      q_elem   = pick_elem(q_row, elem_idx);
      k_elem   = pick_elem(k_bank[row], elem_idx);
      prod_c   = $signed({{DATA_WIDTH{q_elem[DATA_WIDTH-1]}}, q_elem}) *
                 $signed({{DATA_WIDTH{k_elem[DATA_WIDTH-1]}}, k_elem});
      prod_ext = $signed({{(ACC_W - PROD_W){prod_p0[PROD_W-1]}}, prod_p0});
      acc_sum  = acc + prod_ext;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (bus.en_loadk)                  state_nxt = LOADK;
            else if (bus.q_valid && k_full)    state_nxt = COMPUTE;
         end
         LOADK: begin
            if (!bus.en_loadk)                 state_nxt = IDLE;
         end
         COMPUTE: begin
            if (vld_p0 && last_p0)             state_nxt = OUT;
         end
         OUT: begin
            if (score_valid && bus.score_ready)
               state_nxt = (row == LAST_ROW) ? IDLE : COMPUTE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < SEQ_LENGTH; i++) k_bank[i] <= '0;
         row_valid   <= '0;
         q_row       <= '0;
         row         <= '0;
         elem        <= '0;
         prod_p0     <= '0;
         vld_p0      <= 1'b0;
         last_p0     <= 1'b0;
         acc         <= '0;
         done_ld_k   <= 1'b0;
         q_accept    <= 1'b0;
         score       <= '0;
         score_idx   <= '0;
         score_valid <= 1'b0;
         done_qk     <= 1'b0;
      end else begin
         done_ld_k <= 1'b0;
         q_accept  <= 1'b0;
         done_qk   <= 1'b0;
         vld_p0    <= 1'b0;
         last_p0   <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.en_loadk) begin
                  row_valid <= '0;
               end else if (bus.q_valid && k_full) begin
                  q_row    <= bus.q_input;
                  q_accept <= 1'b1;
                  row      <= '0;
                  elem     <= '0;
                  acc      <= '0;
               end
            end
            LOADK: begin
               // A beat that arrives in the acknowledge cycle is dropped.
               if (bus.k_valid && !done_ld_k) begin
                  k_bank[bus.k_address]    <= bus.k_input;
                  row_valid[bus.k_address] <= 1'b1;
                  done_ld_k                <= 1'b1;
               end
            end
            COMPUTE: begin
               // p0: multiply one element pair
               if (elem != ELEM_END) begin
                  prod_p0 <= prod_c;
                  vld_p0  <= 1'b1;
                  last_p0 <= (elem == LAST_ELEM);
                  elem    <= elem + 1'b1;
               end
               // p1: accumulate; the last product closes the row
               if (vld_p0) begin
                  acc <= acc_sum;
                  if (last_p0) begin
                     score       <= finalize_score(acc_sum);
                     score_idx   <= row;
                     score_valid <= 1'b1;
                  end
               end
            end
            OUT: begin
               if (score_valid && bus.score_ready) begin
                  score_valid <= 1'b0;
                  if (row == LAST_ROW) begin
                     done_qk <= 1'b1;
                  end else begin
                     row  <= row + 1'b1;
                     elem <= '0;
                     acc  <= '0;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.input_done_ld_k = done_ld_k;
   assign bus.k_full          = k_full;
   assign bus.q_accept        = q_accept;
   assign bus.score_qk_output = score;
   assign bus.score_idx       = score_idx;
   assign bus.score_valid     = score_valid;
   assign bus.done_qk         = done_qk;
endmodule

// File: tb/tb_qk_score_unit.sv
// tb_qk_score_unit
//   Directed and randomized bench for qk_score_unit. A dot-product model
//   computed with plain integer arithmetic supplies the expected scores.
module tb_qk_score_unit;
   localparam int DW  = 8;
   localparam int DK  = 4;
   localparam int SB  = 2;
   localparam int SW  = 32;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   checks = 0;
   int   errors = 0;

   logic [31:0] kmod [4];
   logic [3:0]  mask_mod;

   always #5 clk = ~clk;

   qk_score_if #(.DATA_WIDTH(DW), .D_K(DK), .SEQ_LENGTH_BIT(SB), .SCORE_WIDTH(SW)) bus ();

   qk_score_unit #(.DATA_WIDTH(DW), .D_K(DK), .SEQ_LENGTH_BIT(SB),
                   .SCORE_WIDTH(SW), .SCALE_SHIFT(1)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] exp_score(input logic [31:0] q, input logic [31:0] k);
      int s, a, b;
      s = 0;
      for (int i = 0; i < DK; i++) begin
         a = $signed(q[31 - 8*i -: 8]);
         b = $signed(k[31 - 8*i -: 8]);
         s += a * b;
      end
`ifdef QK_SCORE_SCALE_EN
      s = s >>> 1;
`endif
      return s;
   endfunction

   task automatic begin_load();
      bus.en_loadk = 1'b1;
      tick();
      mask_mod = '0;
   endtask

   task automatic end_load();
      bus.en_loadk = 1'b0;
      tick();
   endtask

   task automatic load_k(input logic [1:0] addr, input logic [31:0] data);
      bus.k_valid = 1'b1; bus.k_address = addr; bus.k_input = data;
      tick();
      bus.k_valid = 1'b0;
      kmod[addr] = data;
      mask_mod[addr] = 1'b1;
      check_eq("ld_pulse", bus.input_done_ld_k, 1);
      check_eq("k_full", bus.k_full, &mask_mod);
      tick();
      check_eq("ld_pulse_end", bus.input_done_ld_k, 0);
      tick();
   endtask

   // Second beat is presented during the acknowledge cycle and must be dropped.
   task automatic load_k_busy(input logic [1:0] addr, input logic [31:0] d1, input logic [31:0] d2);
      bus.k_valid = 1'b1; bus.k_address = addr; bus.k_input = d1;
      tick();
      kmod[addr] = d1;
      mask_mod[addr] = 1'b1;
      check_eq("busy_pulse", bus.input_done_ld_k, 1);
      bus.k_input = d2;
      tick();
      bus.k_valid = 1'b0;
      check_eq("busy_no_pulse", bus.input_done_ld_k, 0);
      tick();
   endtask

   task automatic run_scores(input logic [31:0] q, input int stall_row, input int stall_cyc);
      int cnt;
      bus.q_input = q; bus.q_valid = 1'b1; bus.score_ready = 1'b1;
      cnt = 0;
      tick();
      while (!bus.q_accept && cnt < 8) begin tick(); cnt++; end
      bus.q_valid = 1'b0;
      check_eq("q_accept", bus.q_accept, 1);
      cnt = 0;
      while (!bus.score_valid && cnt < 12) begin tick(); cnt++; end
      check_eq("latency", cnt, DK + 1);
      for (int r = 0; r < 4; r++) begin
         cnt = 0;
         while (!bus.score_valid && cnt < 12) begin tick(); cnt++; end
         check_eq("score_valid", bus.score_valid, 1);
         check_eq("score_idx", bus.score_idx, r);
         check_eq("score", bus.score_qk_output, exp_score(q, kmod[r]));
         if (r == stall_row) begin
            bus.score_ready = 1'b0;
            for (int s = 0; s < stall_cyc; s++) begin
               tick();
               check_eq("stall_valid", bus.score_valid, 1);
               check_eq("stall_score", bus.score_qk_output, exp_score(q, kmod[r]));
               check_eq("stall_idx", bus.score_idx, r);
               check_eq("stall_done", bus.done_qk, 0);
            end
            bus.score_ready = 1'b1;
         end
         tick();
         check_eq("accept_clr", bus.score_valid, 0);
         check_eq("done_qk", bus.done_qk, (r == 3) ? 1 : 0);
      end
      tick();
      check_eq("done_end", bus.done_qk, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1);
   end

   initial begin
      logic [31:0] v;
      int off, cnt;
      bus.en_loadk = 0; bus.k_valid = 0; bus.k_input = '0; bus.k_address = '0;
      bus.q_valid = 0; bus.q_input = '0; bus.score_ready = 1'b1;
      for (int i = 0; i < 4; i++) kmod[i] = '0;
      mask_mod = '0;
      repeat (3) tick();
      check_eq("rst_score_valid", bus.score_valid, 0);
      check_eq("rst_score", bus.score_qk_output, 0);
      check_eq("rst_idx", bus.score_idx, 0);
      check_eq("rst_k_full", bus.k_full, 0);
      check_eq("rst_q_accept", bus.q_accept, 0);
      check_eq("rst_ld", bus.input_done_ld_k, 0);
      check_eq("rst_done", bus.done_qk, 0);
      rst = 1'b1;
      tick();

      // Q without a full K bank is ignored.
      bus.q_valid = 1'b1; bus.q_input = 32'h01010101;
      repeat (4) begin
         tick();
         check_eq("guard_q_accept", bus.q_accept, 0);
         check_eq("guard_valid", bus.score_valid, 0);
      end
      bus.q_valid = 1'b0;

      begin_load();
      load_k(0, 32'h01020304);
      load_k(1, 32'hFFFFFFFF);
      load_k(2, 32'h7F7F7F7F);
      load_k(3, 32'h80808080);
      end_load();
      check_eq("tp_k_full", bus.k_full, 1);

      run_scores(32'h01010101, -1, 0);
      run_scores(32'h80808080, 3, 6);

      // Duplicate address and busy-cycle beat.
      begin_load();
      check_eq("reload_k_full", bus.k_full, 0);
      load_k_busy(0, 32'h02FE0510, 32'h7F7F7F7F);
      load_k(1, 32'hFF01FF01);
      load_k(2, 32'h11111111);
      load_k(3, 32'h0A0B0C0D);
      load_k(2, 32'h05F60708);
      end_load();
      run_scores(32'h03FD7F80, 1, 2);

      // en_loadk wins over q_valid in the same cycle.
      bus.en_loadk = 1'b1; bus.q_valid = 1'b1; bus.q_input = 32'h01010101;
      tick();
      bus.q_valid = 1'b0;
      mask_mod = '0;
      check_eq("prio_q_accept", bus.q_accept, 0);
      check_eq("prio_k_full", bus.k_full, 0);

      for (int it = 0; it < 6; it++) begin
         if (it != 0) begin_load();
         off = $urandom_range(0, 3);
         for (int i = 0; i < 4; i++) begin
            v = $urandom();
            load_k(2'((off + i) % 4), v);
         end
         if ($urandom_range(0, 1) == 1) begin
            v = $urandom();
            load_k(2'($urandom_range(0, 3)), v);
         end
         end_load();
         v = $urandom();
         run_scores(v, $urandom_range(0, 3), $urandom_range(0, 5));
      end

      // Reset during the row-1 accumulate.
      bus.q_input = 32'h01020304; bus.q_valid = 1'b1;
      cnt = 0;
      while (!bus.score_valid && cnt < 20) begin tick(); cnt++; if (bus.q_accept) bus.q_valid = 1'b0; end
      bus.q_valid = 1'b0;
      check_eq("mid_row0_valid", bus.score_valid, 1);
      tick();
      tick();
      #2 rst = 1'b0;
      #1;
      check_eq("mid_score_valid", bus.score_valid, 0);
      check_eq("mid_score", bus.score_qk_output, 0);
      check_eq("mid_idx", bus.score_idx, 0);
      check_eq("mid_k_full", bus.k_full, 0);
      check_eq("mid_done", bus.done_qk, 0);
      repeat (2) tick();
      rst = 1'b1;
      for (int i = 0; i < 12; i++) begin
         tick();
         check_eq("post_rst_done", bus.done_qk, 0);
         check_eq("post_rst_valid", bus.score_valid, 0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
